uart_axil_arbiter: RTL and testbench
====================================

UART_AXIL_ARBITER -- requirements
Module: uart_axil_arbiter

Interface
REQ-001 Parameter ADDR_W, default 13: AXI-Lite address width on all ports.
REQ-002 Parameter DATA_W, default 32: AXI-Lite data width on all ports; strobe width is DATA_W/8.
REQ-003 Port chipset_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port chipset_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 Ports s<i>_axi_awaddr/awvalid (in) and s<i>_axi_awready (out), ADDR_W/1/1, for i=0,1: requester write-address channel.
REQ-006 Ports s<i>_axi_wdata/wstrb/wvalid (in) and s<i>_axi_wready (out), DATA_W/DATA_W/8/1/1: requester write-data channel.
REQ-007 Ports s<i>_axi_bresp/bvalid (out) and s<i>_axi_bready (in), 2/1/1: requester write-response channel.
REQ-008 Ports s<i>_axi_araddr/arvalid (in) and s<i>_axi_arready (out), ADDR_W/1/1: requester read-address channel.
REQ-009 Ports s<i>_axi_rdata/rresp/rvalid (out) and s<i>_axi_rready (in), DATA_W/2/1/1: requester read-data channel.
REQ-010 Ports uart_axi_aw*, uart_axi_w*, uart_axi_b*, uart_axi_ar*, uart_axi_r*: the same five channels with directions mirrored, forming the single shared AXI-Lite manager port to the UART.

Function
REQ-011 The block SHALL serialise the two requesters onto uart_axi_*, with exactly one transaction outstanding at a time.
REQ-012 FSM states SHALL be IDLE, WR (AW/W forward), WB (B wait), RD (AR forward) and RR (R wait).
REQ-013 A write request from s<i> SHALL be awvalid&wvalid; a read request SHALL be arvalid.
REQ-014 Within one requester, a write SHALL win over a simultaneous read.
REQ-015 Between requesters, IDLE SHALL grant by round-robin: pointer prio gives preference; after a transaction completes, prio = 1 - granted index; an uncontested requester is granted regardless of prio.
REQ-016 The grant SHALL be registered in IDLE; uart_axi_awvalid/wvalid or uart_axi_arvalid SHALL assert in the next cycle, i.e. one cycle of arbitration latency.
REQ-017 In WR, AW and W SHALL be forwarded concurrently and each SHALL be retired independently. Flags aw_done and w_done are set on their downstream handshakes and the corresponding valid is dropped in the following cycle. The FSM moves to WB once both flags are set, including when both handshakes occur in the same cycle.
REQ-018 Upstream s<g>_axi_awready/wready/arready SHALL combinationally equal the downstream ready, gated by the grant and the state. The non-granted requester's readies SHALL be 0.
REQ-019 In WB, uart_axi_bready SHALL equal s<g>_axi_bready, and bvalid/bresp SHALL route only to s<g>. The B handshake returns the FSM to IDLE.
REQ-020 In RD the AR handshake SHALL move the FSM to RR. In RR the R channel SHALL route as in REQ-019, and the R handshake returns the FSM to IDLE.
REQ-021 Payloads (addr, data, strb, resp) SHALL pass through unmodified.
REQ-022 Non-granted requester bvalid/rvalid SHALL be 0. A requester's pending request SHALL NOT be consumed while it is not granted.
REQ-023 Downstream valids SHALL be 0 in IDLE, and a new transaction SHALL NOT start in the same cycle as a response handshake.

Reset
REQ-024 While chipset_rst_n=0, the following SHALL all be 0 asynchronously: FSM = IDLE, prio = 0, aw_done = w_done = 0, every *valid and *ready output, and every resp/data output.
REQ-025 A reset asserted mid-transaction SHALL abandon the transaction; no response is replayed after release.
REQ-026 The first grant after reset release SHALL be made in IDLE no earlier than the first rising edge with chipset_rst_n=1.

Verification
REQ-027 s0 write addr 0x004, data 0x41, uart awready=wready=1 on the first valid cycle -> one AW and one W handshake, s0 bresp=0, FSM back to IDLE, next prio=1.
REQ-028 s0 and s1 both assert arvalid at reset release -> s0 served first, then s1. Each rdata is delivered only to its own requester, and prio ends at 0.
REQ-029 uart wready asserted 3 cycles before awready -> wvalid drops after its handshake, awvalid is held until it completes, and exactly one B is returned to the granted requester.
REQ-030 s1 presents both a write and a read at once -> the write completes first and the read is granted in a later IDLE cycle.
REQ-031 chipset_rst_n pulsed low while in RR -> all valids/readies are 0 in the same cycle, no response reaches any requester, and a fresh request after release proceeds normally.
REQ-032 uart returns bresp=2'b10 -> s<g>_axi_bresp=2'b10, unmodified.

Source files
------------

// File: rtl/uart_axil_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_axil_arbiter
// Purpose  : Two-requester AXI-Lite arbiter in front of one UART register
//            port. Only one transaction is outstanding downstream at a time.
//            Between requesters the grant is round-robin. Within one
//            requester, a write is chosen over a simultaneous read.
// Ports    : chipset_clk / chipset_rst_n  - clock, async active-low reset
//            s0_axi_* , s1_axi_*          - AXI-Lite subordinate ports (requesters)
//            uart_axi_*                   - AXI-Lite manager port to the UART
// Revision : 1.0 - initial release
// ============================================================================
module uart_axil_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                  chipset_clk,
    input  logic                  chipset_rst_n,

    // requester 0
    input  logic [ADDR_W-1:0]     s0_axi_awaddr,
    input  logic                  s0_axi_awvalid,
    output logic                  s0_axi_awready,
    input  logic [DATA_W-1:0]     s0_axi_wdata,
    input  logic [DATA_W/8-1:0]   s0_axi_wstrb,
    input  logic                  s0_axi_wvalid,
    output logic                  s0_axi_wready,
    output logic [1:0]            s0_axi_bresp,
    output logic                  s0_axi_bvalid,
    input  logic                  s0_axi_bready,
    input  logic [ADDR_W-1:0]     s0_axi_araddr,
    input  logic                  s0_axi_arvalid,
    output logic                  s0_axi_arready,
    output logic [DATA_W-1:0]     s0_axi_rdata,
    output logic [1:0]            s0_axi_rresp,
    output logic                  s0_axi_rvalid,
    input  logic                  s0_axi_rready,

    // requester 1
    input  logic [ADDR_W-1:0]     s1_axi_awaddr,
    input  logic                  s1_axi_awvalid,
    output logic                  s1_axi_awready,
    input  logic [DATA_W-1:0]     s1_axi_wdata,
    input  logic [DATA_W/8-1:0]   s1_axi_wstrb,
    input  logic                  s1_axi_wvalid,
    output logic                  s1_axi_wready,
    output logic [1:0]            s1_axi_bresp,
    output logic                  s1_axi_bvalid,
    input  logic                  s1_axi_bready,
    input  logic [ADDR_W-1:0]     s1_axi_araddr,
    input  logic                  s1_axi_arvalid,
    output logic                  s1_axi_arready,
    output logic [DATA_W-1:0]     s1_axi_rdata,
    output logic [1:0]            s1_axi_rresp,
    output logic                  s1_axi_rvalid,
    input  logic                  s1_axi_rready,

    // shared manager port to the UART
    output logic [ADDR_W-1:0]     uart_axi_awaddr,
    output logic                  uart_axi_awvalid,
    input  logic                  uart_axi_awready,
    output logic [DATA_W-1:0]     uart_axi_wdata,
    output logic [DATA_W/8-1:0]   uart_axi_wstrb,
    output logic                  uart_axi_wvalid,
    input  logic                  uart_axi_wready,
    input  logic [1:0]            uart_axi_bresp,
    input  logic                  uart_axi_bvalid,
    output logic                  uart_axi_bready,
    output logic [ADDR_W-1:0]     uart_axi_araddr,
    output logic                  uart_axi_arvalid,
    input  logic                  uart_axi_arready,
    input  logic [DATA_W-1:0]     uart_axi_rdata,
    input  logic [1:0]            uart_axi_rresp,
    input  logic                  uart_axi_rvalid,
    output logic                  uart_axi_rready
);

    localparam int c_STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        WB   = 3'd2,
        RD   = 3'd3,
        RR   = 3'd4
    } state_t;

    state_t r_state, w_state_d;
    logic   r_gnt,     w_gnt_d;      // index of the granted requester
    logic   r_prio,    w_prio_d;     // preferred requester on contention
    logic   r_aw_done, w_aw_done_d;
    logic   r_w_done,  w_w_done_d;

    // ------------------------------------------------------------------
    // Request decode and round-robin pick
    // ------------------------------------------------------------------
    logic w_wr0, w_wr1, w_req0, w_req1, w_pick, w_pick_wr;

    assign w_wr0  = s0_axi_awvalid & s0_axi_wvalid;
    assign w_wr1  = s1_axi_awvalid & s1_axi_wvalid;
    assign w_req0 = w_wr0 | s0_axi_arvalid;
    assign w_req1 = w_wr1 | s1_axi_arvalid;

    // prio only matters on contention; a lone requester always wins
    assign w_pick    = w_req1 & (~w_req0 | r_prio);
    assign w_pick_wr = w_pick ? w_wr1 : w_wr0;

    // ------------------------------------------------------------------
    // Granted-requester views
    // ------------------------------------------------------------------
    logic                w_sel0, w_sel1;
    logic                w_in_wr, w_in_wb, w_in_rd, w_in_rr;
    logic [ADDR_W-1:0]   w_g_awaddr, w_g_araddr;
    logic [DATA_W-1:0]   w_g_wdata;
    logic [c_STRB_W-1:0] w_g_wstrb;
    logic                w_g_awvalid, w_g_wvalid, w_g_arvalid;
    logic                w_g_bready, w_g_rready;

    assign w_sel0 = ~r_gnt;
    assign w_sel1 =  r_gnt;

    assign w_in_wr = (r_state == WR);
    assign w_in_wb = (r_state == WB);
    assign w_in_rd = (r_state == RD);
    assign w_in_rr = (r_state == RR);

    assign w_g_awaddr  = r_gnt ? s1_axi_awaddr  : s0_axi_awaddr;
    assign w_g_awvalid = r_gnt ? s1_axi_awvalid : s0_axi_awvalid;
    assign w_g_wdata   = r_gnt ? s1_axi_wdata   : s0_axi_wdata;
    assign w_g_wstrb   = r_gnt ? s1_axi_wstrb   : s0_axi_wstrb;
    assign w_g_wvalid  = r_gnt ? s1_axi_wvalid  : s0_axi_wvalid;
    assign w_g_bready  = r_gnt ? s1_axi_bready  : s0_axi_bready;
    assign w_g_araddr  = r_gnt ? s1_axi_araddr  : s0_axi_araddr;
    assign w_g_arvalid = r_gnt ? s1_axi_arvalid : s0_axi_arvalid;
    assign w_g_rready  = r_gnt ? s1_axi_rready  : s0_axi_rready;

    // ------------------------------------------------------------------
    // Downstream manager port. Payloads are zeroed outside their state so
    // that nothing stale is visible while idle or in reset.
    // ------------------------------------------------------------------
    assign uart_axi_awvalid = w_in_wr & ~r_aw_done & w_g_awvalid;
    assign uart_axi_awaddr  = w_in_wr ? w_g_awaddr : '0;
    assign uart_axi_wvalid  = w_in_wr & ~r_w_done & w_g_wvalid;
    assign uart_axi_wdata   = w_in_wr ? w_g_wdata : '0;
    assign uart_axi_wstrb   = w_in_wr ? w_g_wstrb : '0;
    assign uart_axi_bready  = w_in_wb & w_g_bready;
    assign uart_axi_arvalid = w_in_rd & w_g_arvalid;
    assign uart_axi_araddr  = w_in_rd ? w_g_araddr : '0;
    assign uart_axi_rready  = w_in_rr & w_g_rready;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

    assign w_aw_hs = uart_axi_awvalid & uart_axi_awready;
    assign w_w_hs  = uart_axi_wvalid  & uart_axi_wready;
    assign w_b_hs  = uart_axi_bready  & uart_axi_bvalid;
    assign w_ar_hs = uart_axi_arvalid & uart_axi_arready;
    assign w_r_hs  = uart_axi_rready  & uart_axi_rvalid;

    // ------------------------------------------------------------------
    // Upstream readies and responses: only the granted requester sees
    // anything; the other one is held off with all zeros.
    // ------------------------------------------------------------------
    assign s0_axi_awready = w_in_wr & ~r_aw_done & w_sel0 & uart_axi_awready;
    assign s1_axi_awready = w_in_wr & ~r_aw_done & w_sel1 & uart_axi_awready;
    assign s0_axi_wready  = w_in_wr & ~r_w_done  & w_sel0 & uart_axi_wready;
    assign s1_axi_wready  = w_in_wr & ~r_w_done  & w_sel1 & uart_axi_wready;
    assign s0_axi_arready = w_in_rd & w_sel0 & uart_axi_arready;
    assign s1_axi_arready = w_in_rd & w_sel1 & uart_axi_arready;

    assign s0_axi_bvalid  = w_in_wb & w_sel0 & uart_axi_bvalid;
    assign s1_axi_bvalid  = w_in_wb & w_sel1 & uart_axi_bvalid;
    assign s0_axi_bresp   = (w_in_wb & w_sel0) ? uart_axi_bresp : 2'b00;
    assign s1_axi_bresp   = (w_in_wb & w_sel1) ? uart_axi_bresp : 2'b00;

    assign s0_axi_rvalid  = w_in_rr & w_sel0 & uart_axi_rvalid;
    assign s1_axi_rvalid  = w_in_rr & w_sel1 & uart_axi_rvalid;
    assign s0_axi_rdata   = (w_in_rr & w_sel0) ? uart_axi_rdata : '0;
    assign s1_axi_rdata   = (w_in_rr & w_sel1) ? uart_axi_rdata : '0;
    assign s0_axi_rresp   = (w_in_rr & w_sel0) ? uart_axi_rresp : 2'b00;
    assign s1_axi_rresp   = (w_in_rr & w_sel1) ? uart_axi_rresp : 2'b00;

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state;
        w_gnt_d     = r_gnt;
        w_prio_d    = r_prio;
        w_aw_done_d = 1'b0;
        w_w_done_d  = 1'b0;

        case (r_state)
            IDLE: begin
                // grant is only registered here; forwarding begins next cycle
                if (w_req0 | w_req1) begin
                    w_gnt_d   = w_pick;
                    w_state_d = w_pick_wr ? WR : RD;
                end
            end
            WR: begin
                // AW and W retire independently; leave once both are in,
                // including when both complete on the same edge
                if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                    w_state_d = WB;
                end else begin
                    w_aw_done_d = r_aw_done | w_aw_hs;
                    w_w_done_d  = r_w_done  | w_w_hs;
                end
            end
            WB: begin
                if (w_b_hs) begin
                    w_state_d = IDLE;
                    w_prio_d  = ~r_gnt;
                end
            end
            RD: begin
                if (w_ar_hs) begin
                    w_state_d = RR;
                end
            end
            RR: begin
                if (w_r_hs) begin
                    w_state_d = IDLE;
                    w_prio_d  = ~r_gnt;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge chipset_clk or negedge chipset_rst_n) begin
        if (!chipset_rst_n) begin
            r_state   <= IDLE;
            r_gnt     <= 1'b0;
            r_prio    <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_gnt     <= w_gnt_d;
            r_prio    <= w_prio_d;
            r_aw_done <= w_aw_done_d;
            r_w_done  <= w_w_done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_axil_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_axil_arbiter
// Purpose  : Directed self-checking bench for uart_axil_arbiter. The bench
//            plays both requesters and the UART; inputs change on the
//            falling edge and outputs are sampled 1ns after it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_axil_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    logic chipset_clk = 1'b0;
    logic chipset_rst_n;

    logic [ADDR_W-1:0] s0_axi_awaddr, s1_axi_awaddr, s0_axi_araddr, s1_axi_araddr;
    logic s0_axi_awvalid, s1_axi_awvalid, s0_axi_awready, s1_axi_awready;
    logic [DATA_W-1:0] s0_axi_wdata, s1_axi_wdata;
    logic [DATA_W/8-1:0] s0_axi_wstrb, s1_axi_wstrb;
    logic s0_axi_wvalid, s1_axi_wvalid, s0_axi_wready, s1_axi_wready;
    logic [1:0] s0_axi_bresp, s1_axi_bresp;
    logic s0_axi_bvalid, s1_axi_bvalid, s0_axi_bready, s1_axi_bready;
    logic s0_axi_arvalid, s1_axi_arvalid, s0_axi_arready, s1_axi_arready;
    logic [DATA_W-1:0] s0_axi_rdata, s1_axi_rdata;
    logic [1:0] s0_axi_rresp, s1_axi_rresp;
    logic s0_axi_rvalid, s1_axi_rvalid, s0_axi_rready, s1_axi_rready;

    logic [ADDR_W-1:0] uart_axi_awaddr, uart_axi_araddr;
    logic uart_axi_awvalid, uart_axi_awready;
    logic [DATA_W-1:0] uart_axi_wdata, uart_axi_rdata;
    logic [DATA_W/8-1:0] uart_axi_wstrb;
    logic uart_axi_wvalid, uart_axi_wready;
    logic [1:0] uart_axi_bresp, uart_axi_rresp;
    logic uart_axi_bvalid, uart_axi_bready;
    logic uart_axi_arvalid, uart_axi_arready;
    logic uart_axi_rvalid, uart_axi_rready;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 chipset_clk = ~chipset_clk;

    uart_axil_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .chipset_clk      (chipset_clk),
        .chipset_rst_n    (chipset_rst_n),
        .s0_axi_awaddr    (s0_axi_awaddr),
        .s0_axi_awvalid   (s0_axi_awvalid),
        .s0_axi_awready   (s0_axi_awready),
        .s0_axi_wdata     (s0_axi_wdata),
        .s0_axi_wstrb     (s0_axi_wstrb),
        .s0_axi_wvalid    (s0_axi_wvalid),
        .s0_axi_wready    (s0_axi_wready),
        .s0_axi_bresp     (s0_axi_bresp),
        .s0_axi_bvalid    (s0_axi_bvalid),
        .s0_axi_bready    (s0_axi_bready),
        .s0_axi_araddr    (s0_axi_araddr),
        .s0_axi_arvalid   (s0_axi_arvalid),
        .s0_axi_arready   (s0_axi_arready),
        .s0_axi_rdata     (s0_axi_rdata),
        .s0_axi_rresp     (s0_axi_rresp),
        .s0_axi_rvalid    (s0_axi_rvalid),
        .s0_axi_rready    (s0_axi_rready),
        .s1_axi_awaddr    (s1_axi_awaddr),
        .s1_axi_awvalid   (s1_axi_awvalid),
        .s1_axi_awready   (s1_axi_awready),
        .s1_axi_wdata     (s1_axi_wdata),
        .s1_axi_wstrb     (s1_axi_wstrb),
        .s1_axi_wvalid    (s1_axi_wvalid),
        .s1_axi_wready    (s1_axi_wready),
        .s1_axi_bresp     (s1_axi_bresp),
        .s1_axi_bvalid    (s1_axi_bvalid),
        .s1_axi_bready    (s1_axi_bready),
        .s1_axi_araddr    (s1_axi_araddr),
        .s1_axi_arvalid   (s1_axi_arvalid),
        .s1_axi_arready   (s1_axi_arready),
        .s1_axi_rdata     (s1_axi_rdata),
        .s1_axi_rresp     (s1_axi_rresp),
        .s1_axi_rvalid    (s1_axi_rvalid),
        .s1_axi_rready    (s1_axi_rready),
        .uart_axi_awaddr  (uart_axi_awaddr),
        .uart_axi_awvalid (uart_axi_awvalid),
        .uart_axi_awready (uart_axi_awready),
        .uart_axi_wdata   (uart_axi_wdata),
        .uart_axi_wstrb   (uart_axi_wstrb),
        .uart_axi_wvalid  (uart_axi_wvalid),
        .uart_axi_wready  (uart_axi_wready),
        .uart_axi_bresp   (uart_axi_bresp),
        .uart_axi_bvalid  (uart_axi_bvalid),
        .uart_axi_bready  (uart_axi_bready),
        .uart_axi_araddr  (uart_axi_araddr),
        .uart_axi_arvalid (uart_axi_arvalid),
        .uart_axi_arready (uart_axi_arready),
        .uart_axi_rdata   (uart_axi_rdata),
        .uart_axi_rresp   (uart_axi_rresp),
        .uart_axi_rvalid  (uart_axi_rvalid),
        .uart_axi_rready  (uart_axi_rready)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge chipset_clk);
        #1;
    endtask

    // Wait (bounded) for a downstream valid; lat is 0 when it appears on the
    // first falling edge after the grant edge.
    task automatic wait_dn(input bit is_wr, output int lat);
        lat = 0;
        step();
        while (!(is_wr ? (uart_axi_awvalid | uart_axi_wvalid) : uart_axi_arvalid) && lat < 20) begin
            step();
            lat++;
        end
    endtask

    // UART side of one read for requester idx; responds immediately.
    task automatic serve_read(input int idx, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] data);
        int lat;
        wait_dn(1'b0, lat);
        check_eq("ar_latency", lat, 0);
        check_eq("ar_awvalid_quiet", uart_axi_awvalid, 0);
        check_eq("araddr", uart_axi_araddr, addr);
        uart_axi_arready = 1'b1;
        #1;
        check_eq("arready_gnt", idx ? s1_axi_arready : s0_axi_arready, 1);
        check_eq("arready_other", idx ? s0_axi_arready : s1_axi_arready, 0);
        step();
        uart_axi_arready = 1'b0;
        if (idx == 1) s1_axi_arvalid = 1'b0; else s0_axi_arvalid = 1'b0;
        uart_axi_rvalid = 1'b1;
        uart_axi_rdata  = data;
        uart_axi_rresp  = 2'b00;
        #1;
        check_eq("arvalid_after_hs", uart_axi_arvalid, 0);
        check_eq("rvalid_gnt", idx ? s1_axi_rvalid : s0_axi_rvalid, 1);
        check_eq("rdata_gnt", idx ? s1_axi_rdata : s0_axi_rdata, data);
        check_eq("rvalid_other", idx ? s0_axi_rvalid : s1_axi_rvalid, 0);
        check_eq("rdata_other", idx ? s0_axi_rdata : s1_axi_rdata, 0);
        check_eq("uart_rready", uart_axi_rready, 1);
        step();
        uart_axi_rvalid = 1'b0;
        uart_axi_rdata  = '0;
        #1;
        check_eq("rvalid_after", idx ? s1_axi_rvalid : s0_axi_rvalid, 0);
    endtask

    // UART side of one write for requester idx with AW/W ready at once.
    task automatic serve_write(input int idx, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input logic [1:0] resp);
        int lat;
        wait_dn(1'b1, lat);
        check_eq("aw_latency", lat, 0);
        check_eq("aw_valid", uart_axi_awvalid, 1);
        check_eq("w_valid", uart_axi_wvalid, 1);
        check_eq("wr_arvalid_quiet", uart_axi_arvalid, 0);
        check_eq("awaddr", uart_axi_awaddr, addr);
        check_eq("wdata", uart_axi_wdata, data);
        check_eq("wstrb", uart_axi_wstrb, 4'hF);
        uart_axi_awready = 1'b1;
        uart_axi_wready  = 1'b1;
        #1;
        check_eq("awready_gnt", idx ? s1_axi_awready : s0_axi_awready, 1);
        check_eq("wready_gnt", idx ? s1_axi_wready : s0_axi_wready, 1);
        check_eq("awready_other", idx ? s0_axi_awready : s1_axi_awready, 0);
        step();
        uart_axi_awready = 1'b0;
        uart_axi_wready  = 1'b0;
        if (idx == 1) begin s1_axi_awvalid = 1'b0; s1_axi_wvalid = 1'b0; end
        else          begin s0_axi_awvalid = 1'b0; s0_axi_wvalid = 1'b0; end
        uart_axi_bvalid = 1'b1;
        uart_axi_bresp  = resp;
        #1;
        check_eq("wb_awvalid_low", uart_axi_awvalid | uart_axi_wvalid, 0);
        check_eq("bvalid_gnt", idx ? s1_axi_bvalid : s0_axi_bvalid, 1);
        check_eq("bresp_gnt", idx ? s1_axi_bresp : s0_axi_bresp, resp);
        check_eq("bvalid_other", idx ? s0_axi_bvalid : s1_axi_bvalid, 0);
        check_eq("uart_bready", uart_axi_bready, 1);
        step();
        uart_axi_bvalid = 1'b0;
        uart_axi_bresp  = 2'b00;
        #1;
        check_eq("bvalid_after", idx ? s1_axi_bvalid : s0_axi_bvalid, 0);
    endtask

    initial begin
        chipset_rst_n = 1'b0;
        s0_axi_awaddr = '0; s0_axi_awvalid = 0; s0_axi_wdata = '0; s0_axi_wstrb = 4'hF;
        s0_axi_wvalid = 0;  s0_axi_bready = 1;  s0_axi_araddr = '0; s0_axi_arvalid = 0;
        s0_axi_rready = 1;
        s1_axi_awaddr = '0; s1_axi_awvalid = 0; s1_axi_wdata = '0; s1_axi_wstrb = 4'hF;
        s1_axi_wvalid = 0;  s1_axi_bready = 1;  s1_axi_araddr = '0; s1_axi_arvalid = 0;
        s1_axi_rready = 1;
        uart_axi_awready = 0; uart_axi_wready = 0; uart_axi_bresp = 2'b00;
        uart_axi_bvalid = 1;  uart_axi_arready = 1; uart_axi_rdata = 32'hCAFE_F00D;
        uart_axi_rresp = 2'b11; uart_axi_rvalid = 1;

        // reset: downstream responses are present but must not leak out
        step();
        step();
        check_eq("rst_s0_bvalid", s0_axi_bvalid, 0);
        check_eq("rst_s1_rvalid", s1_axi_rvalid, 0);
        check_eq("rst_s0_rdata", s0_axi_rdata, 0);
        check_eq("rst_s0_rresp", s0_axi_rresp, 0);
        check_eq("rst_s1_arready", s1_axi_arready, 0);
        check_eq("rst_uart_valids", {uart_axi_awvalid, uart_axi_wvalid, uart_axi_arvalid}, 0);
        check_eq("rst_uart_readies", {uart_axi_bready, uart_axi_rready}, 0);
        uart_axi_bvalid = 0; uart_axi_rvalid = 0; uart_axi_arready = 0;
        uart_axi_rdata = '0; uart_axi_rresp = 2'b00;

        // both requesters read at release: s0 first (prio 0), then s1
        s0_axi_araddr = 13'h010; s0_axi_arvalid = 1;
        s1_axi_araddr = 13'h014; s1_axi_arvalid = 1;
        @(negedge chipset_clk);
        chipset_rst_n = 1'b1;
        #1;
        check_eq("idle_arvalid", uart_axi_arvalid, 0);
        serve_read(0, 13'h010, 32'h0000_00A0);
        serve_read(1, 13'h014, 32'h0000_00B1);

        // s0 write 0x41 to 0x004, AW and W accepted together
        s0_axi_awaddr = 13'h004; s0_axi_wdata = 32'h41;
        s0_axi_awvalid = 1; s0_axi_wvalid = 1;
        #1;
        check_eq("idle_awready", s0_axi_awready, 0);
        serve_write(0, 13'h004, 32'h41, 2'b00);

        // contention after s0 wrote: prio=1, so s1 goes first
        s0_axi_araddr = 13'h020; s0_axi_arvalid = 1;
        s1_axi_araddr = 13'h024; s1_axi_arvalid = 1;
        serve_read(1, 13'h024, 32'h1111_2222);
        serve_read(0, 13'h020, 32'h3333_4444);

        // s1 write: W accepted three cycles before AW, SLVERR response
        s1_axi_awaddr = 13'h008; s1_axi_wdata = 32'h5A; s1_axi_awvalid = 1; s1_axi_wvalid = 1;
        uart_axi_wready = 1;
        step();
        check_eq("dly_awvalid0", uart_axi_awvalid, 1);
        check_eq("dly_wready0", s1_axi_wready, 1);
        check_eq("dly_awready0", s1_axi_awready, 0);
        step();
        s1_axi_wvalid = 0;
        #1;
        check_eq("dly_wvalid_drop", uart_axi_wvalid, 0);
        check_eq("dly_awvalid1", uart_axi_awvalid, 1);
        check_eq("dly_wready_drop", s1_axi_wready, 0);
        step();
        check_eq("dly_awvalid2", uart_axi_awvalid, 1);
        check_eq("dly_bvalid_early", s1_axi_bvalid, 0);
        step();
        uart_axi_awready = 1;
        #1;
        check_eq("dly_awvalid3", uart_axi_awvalid, 1);
        check_eq("dly_awready3", s1_axi_awready, 1);
        step();
        uart_axi_awready = 0; uart_axi_wready = 0; s1_axi_awvalid = 0;
        uart_axi_bvalid = 1; uart_axi_bresp = 2'b10;
        #1;
        check_eq("dly_bvalid", s1_axi_bvalid, 1);
        check_eq("dly_bresp", s1_axi_bresp, 2'b10);
        check_eq("dly_bvalid_s0", s0_axi_bvalid, 0);
        step();
        uart_axi_bvalid = 1;
        #1;
        check_eq("dly_single_b", s1_axi_bvalid, 0);
        uart_axi_bvalid = 0; uart_axi_bresp = 2'b00;

        // s1 write and read together: write first, read in a later IDLE
        s1_axi_awaddr = 13'h00C; s1_axi_wdata = 32'h77; s1_axi_awvalid = 1; s1_axi_wvalid = 1;
        s1_axi_araddr = 13'h030; s1_axi_arvalid = 1;
        serve_write(1, 13'h00C, 32'h77, 2'b00);
        check_eq("wr_then_rd_idle", uart_axi_arvalid, 0);
        serve_read(1, 13'h030, 32'h0BAD_BEEF);

        // reset pulse while in RR
        s0_axi_araddr = 13'h040; s0_axi_arvalid = 1;
        begin
            int lat;
            wait_dn(1'b0, lat);
            check_eq("rr_ar_seen", uart_axi_arvalid, 1);
        end
        uart_axi_arready = 1;
        step();
        uart_axi_arready = 0; s0_axi_arvalid = 0;
        chipset_rst_n = 0;
        uart_axi_rvalid = 1; uart_axi_rdata = 32'hDEAD_0001;
        #1;
        check_eq("rr_rst_s0_rvalid", s0_axi_rvalid, 0);
        check_eq("rr_rst_s0_rdata", s0_axi_rdata, 0);
        check_eq("rr_rst_rready", uart_axi_rready, 0);
        step();
        uart_axi_rvalid = 0; uart_axi_rdata = '0;
        @(negedge chipset_clk);
        chipset_rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("post_rst_quiet", {s0_axi_rvalid, s1_axi_rvalid, uart_axi_arvalid, uart_axi_rready}, 0);
        end
        s1_axi_araddr = 13'h044; s1_axi_arvalid = 1;
        serve_read(1, 13'h044, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
